axil_sram: RTL and testbench

// - AXI-Lite slave memory that sits directly downstream of the LSU's AXI-Lite master port.
// - Serves LSU loads (AR/R) and stores (AW/W/B) from an internal word array.
// - Independent read and write engines, one outstanding transaction per channel.
// - Fixed, configurable response latency, so the LSU multi-cycle path can be exercised.

---
 rtl/axil_sram.sv | 267 ++++++++++++++++++++++++++
 tb/tb_axil_sram.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_sram.sv
// axil_sram: AXI-Lite slave word memory with independent read/write engines and fixed response latency.
// Optional macro YSYX_23060251_SRAM_RAND_DELAY_EN adds 0..7 LFSR-chosen extra cycles per transaction.

package axil_sram_pkg;
    typedef logic [1:0] axi_resp_t;
    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;
endpackage

module axil_sram
    import axil_sram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned WR_LATENCY  = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        slv_ar_valid_i,
    input  logic [31:0] slv_ar_addr_i,
    output logic        slv_ar_ready_o,
    output logic        slv_r_valid_o,
    output logic [31:0] slv_r_data_o,
    output axi_resp_t   slv_r_resp_o,
    input  logic        slv_r_ready_i,
    input  logic        slv_aw_valid_i,
    input  logic [31:0] slv_aw_addr_i,
    output logic        slv_aw_ready_o,
    input  logic        slv_w_valid_i,
    input  logic [31:0] slv_w_data_i,
    input  logic [3:0]  slv_w_strb_i,
    output logic        slv_w_ready_o,
    output logic        slv_b_valid_o,
    output axi_resp_t   slv_b_resp_o,
    input  logic        slv_b_ready_i
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 5;
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;
    localparam logic [CNT_W-1:0] RD_CNT_BASE = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_CNT_BASE = CNT_W'(WR_LATENCY - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return ({1'b0, off} < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[IDX_W+1:2];
    endfunction

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [CNT_W-1:0] extra_dly;
`ifdef YSYX_23060251_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign extra_dly = {2'b00, lfsr_q[2:0]};
`else
    assign extra_dly = '0;
`endif

    logic [CNT_W-1:0] rd_cnt_init;
    logic [CNT_W-1:0] wr_cnt_init;
    assign rd_cnt_init = RD_CNT_BASE + extra_dly;
    assign wr_cnt_init = WR_CNT_BASE + extra_dly;

    // ---------------- write engine state ----------------
    wr_state_t        wr_state_q;
    logic [CNT_W-1:0] wr_cnt_q;
    logic             aw_held_q, w_held_q;
    logic             aw_ready_q, w_ready_q;
    logic [31:0]      aw_addr_q, w_data_q;
    logic [3:0]       w_strb_q;
    logic             b_valid_q;
    axi_resp_t        b_resp_q;

    logic             aw_hs, w_hs, aw_have, w_have;
    logic             wr_start, wr_commit, wr_in_range;
    logic [31:0]      wr_addr, wr_data, wr_word_d;
    logic [3:0]       wr_strb;
    logic [IDX_W-1:0] wr_idx;

    // Payload comes from the input port when it is captured on the same edge that completes the pair.
    always_comb begin
        aw_hs       = slv_aw_valid_i && aw_ready_q;
        w_hs        = slv_w_valid_i && w_ready_q;
        aw_have     = aw_held_q || aw_hs;
        w_have      = w_held_q || w_hs;
        wr_addr     = aw_held_q ? aw_addr_q : slv_aw_addr_i;
        wr_data     = w_held_q ? w_data_q : slv_w_data_i;
        wr_strb     = w_held_q ? w_strb_q : slv_w_strb_i;
        wr_start    = (wr_state_q == W_IDLE) && aw_have && w_have;
        wr_commit   = (wr_start && (wr_cnt_init == '0)) ||
                      ((wr_state_q == W_WAIT) && (wr_cnt_q == CNT_W'(1)));
        wr_in_range = in_range(wr_addr);
        wr_idx      = word_idx(wr_addr);
        wr_word_d   = mem_q[wr_idx];
        for (int unsigned b = 0; b < 4; b++) begin
            if (wr_strb[b]) begin
                wr_word_d[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_commit && wr_in_range) begin
            mem_q[wr_idx] <= wr_word_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q <= W_IDLE;
            wr_cnt_q   <= '0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held_q  <= 1'b1;
                        aw_ready_q <= 1'b0;
                        aw_addr_q  <= slv_aw_addr_i;
                    end
                    if (w_hs) begin
                        w_held_q  <= 1'b1;
                        w_ready_q <= 1'b0;
                        w_data_q  <= slv_w_data_i;
                        w_strb_q  <= slv_w_strb_i;
                    end
                    if (wr_commit) begin
                        wr_state_q <= W_RESP;
                        b_valid_q  <= 1'b1;
                        b_resp_q   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                    end else if (wr_start) begin
                        wr_state_q <= W_WAIT;
                        wr_cnt_q   <= wr_cnt_init;
                    end
                end
                W_WAIT: begin
                    if (wr_commit) begin
                        wr_state_q <= W_RESP;
                        wr_cnt_q   <= '0;
                        b_valid_q  <= 1'b1;
                        b_resp_q   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        wr_cnt_q <= wr_cnt_q - CNT_W'(1);
                    end
                end
                W_RESP: begin
                    if (slv_b_ready_i) begin
                        wr_state_q <= W_IDLE;
                        b_valid_q  <= 1'b0;
                        aw_held_q  <= 1'b0;
                        w_held_q   <= 1'b0;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // ---------------- read engine ----------------
    rd_state_t        rd_state_q;
    logic [CNT_W-1:0] rd_cnt_q;
    logic [31:0]      rd_addr_q;
    logic             ar_ready_q;
    logic             r_valid_q;
    logic [31:0]      r_data_q;
    axi_resp_t        r_resp_q;

    logic             ar_hs, rd_sample, rd_in_range;
    logic [31:0]      rd_addr_sel, rd_word;
    logic [IDX_W-1:0] rd_idx;

    // A write committing on the sampling edge is forwarded so the read observes the new word.
    always_comb begin
        ar_hs       = slv_ar_valid_i && ar_ready_q;
        rd_addr_sel = (rd_state_q == R_IDLE) ? slv_ar_addr_i : rd_addr_q;
        rd_idx      = word_idx(rd_addr_sel);
        rd_in_range = in_range(rd_addr_sel);
        rd_sample   = ((rd_state_q == R_IDLE) && ar_hs && (rd_cnt_init == '0)) ||
                      ((rd_state_q == R_WAIT) && (rd_cnt_q == CNT_W'(1)));
        rd_word     = (wr_commit && wr_in_range && (wr_idx == rd_idx)) ? wr_word_d : mem_q[rd_idx];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= '0;
            rd_addr_q  <= '0;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
        end else begin
            if (rd_sample) begin
                rd_state_q <= R_RESP;
                rd_cnt_q   <= '0;
                r_valid_q  <= 1'b1;
                r_data_q   <= rd_in_range ? rd_word : '0;
                r_resp_q   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
            case (rd_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        ar_ready_q <= 1'b0;
                        rd_addr_q  <= slv_ar_addr_i;
                        if (!rd_sample) begin
                            rd_state_q <= R_WAIT;
                            rd_cnt_q   <= rd_cnt_init;
                        end
                    end
                end
                R_WAIT: begin
                    if (!rd_sample) begin
                        rd_cnt_q <= rd_cnt_q - CNT_W'(1);
                    end
                end
                R_RESP: begin
                    if (slv_r_ready_i) begin
                        rd_state_q <= R_IDLE;
                        r_valid_q  <= 1'b0;
                        ar_ready_q <= 1'b1;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign slv_ar_ready_o = ar_ready_q;
    assign slv_r_valid_o  = r_valid_q;
    assign slv_r_data_o   = r_data_q;
    assign slv_r_resp_o   = r_resp_q;
    assign slv_aw_ready_o = aw_ready_q;
    assign slv_w_ready_o  = w_ready_q;
    assign slv_b_valid_o  = b_valid_q;
    assign slv_b_resp_o   = b_resp_q;

endmodule

// File: tb/tb_axil_sram.sv
// Scoreboard bench for axil_sram: directed stimulus pushes expected R/B responses, a monitor pops and checks them.
module tb_axil_sram;
    import axil_sram_pkg::*;

    localparam int RD_LAT = 4;
    localparam int WR_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ar_valid = 1'b0;
    logic [31:0] ar_addr = '0;
    logic        ar_ready;
    logic        r_valid;
    logic [31:0] r_data;
    axi_resp_t   r_resp;
    logic        r_ready = 1'b1;
    logic        aw_valid = 1'b0;
    logic [31:0] aw_addr = '0;
    logic        aw_ready;
    logic        w_valid = 1'b0;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = '0;
    logic        w_ready;
    logic        b_valid;
    axi_resp_t   b_resp;
    logic        b_ready = 1'b1;

    axil_sram #(
        .DEPTH_WORDS(4096),
        .BASE_ADDR  (32'h8000_0000),
        .RD_LATENCY (RD_LAT),
        .WR_LATENCY (WR_LAT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .slv_ar_valid_i(ar_valid),
        .slv_ar_addr_i (ar_addr),
        .slv_ar_ready_o(ar_ready),
        .slv_r_valid_o (r_valid),
        .slv_r_data_o  (r_data),
        .slv_r_resp_o  (r_resp),
        .slv_r_ready_i (r_ready),
        .slv_aw_valid_i(aw_valid),
        .slv_aw_addr_i (aw_addr),
        .slv_aw_ready_o(aw_ready),
        .slv_w_valid_i (w_valid),
        .slv_w_data_i  (w_data),
        .slv_w_strb_i  (w_strb),
        .slv_w_ready_o (w_ready),
        .slv_b_valid_o (b_valid),
        .slv_b_resp_o  (b_resp),
        .slv_b_ready_i (b_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        axi_resp_t   resp;
        int          cyc;
    } exp_t;

    exp_t exp_r[$];
    exp_t exp_b[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Monitor: compare on every R and B handshake, independent of the stimulus.
    always @(negedge clk) begin
        exp_t e;
        if (r_valid && r_ready) begin
            if (exp_r.size() == 0) begin
                chk("r_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_r.pop_front();
                chk("r_data", r_data, e.data);
                chk("r_resp", 32'(r_resp), 32'(e.resp));
                if (e.cyc >= 0) chk("r_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (b_valid && b_ready) begin
            if (exp_b.size() == 0) begin
                chk("b_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_b.pop_front();
                chk("b_resp", 32'(b_resp), 32'(e.resp));
                if (e.cyc >= 0) chk("b_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) fail("drain");
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input axi_resp_t er);
        int n = 0;
        exp_t e;
        @(posedge clk); #1;
        ar_valid = 1'b1;
        ar_addr  = a;
        while (!ar_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) fail("ar_accept");
        @(posedge clk); #1;
        ar_valid = 1'b0;
        e.data = ed; e.resp = er; e.cyc = cyc + RD_LAT - 1;
        // cyc now names the handshake edge plus one; response edge is handshake + RD_LAT
        e.cyc = cyc - 1 + RD_LAT;
        exp_r.push_back(e);
        drain();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input axi_resp_t er,
                            input bit timed, input bit wait_done);
        int   n = 0;
        bit   aw_done = 0, w_done = 0, aw_go, w_go;
        exp_t e;
        @(posedge clk); #1;
        aw_addr  = a; w_data = d; w_strb = s;
        aw_valid = (aw_dly == 0);
        w_valid  = (w_dly == 0);
        while (!(aw_done && w_done) && n < 50) begin
            aw_go = aw_valid && aw_ready;
            w_go  = w_valid && w_ready;
            @(posedge clk); #1;
            n++;
            if (aw_go) aw_done = 1;
            if (w_go) w_done = 1;
            aw_valid = !aw_done && (n >= aw_dly);
            w_valid  = !w_done && (n >= w_dly);
        end
        if (n >= 50) fail("aw_w_accept");
        e.data = '0; e.resp = er;
        e.cyc  = timed ? (cyc - 1 + WR_LAT) : -1;
        exp_b.push_back(e);
        if (wait_done) drain();
    endtask

    initial begin
        int n;
        exp_t e;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ar_ready", 32'(ar_ready), 32'd1);
            chk("idle_aw_ready", 32'(aw_ready), 32'd1);
            chk("idle_w_ready", 32'(w_ready), 32'd1);
            chk("idle_r_valid", 32'(r_valid), 32'd0);
            chk("idle_b_valid", 32'(b_valid), 32'd0);
            chk("idle_resps", 32'({r_resp, b_resp}), 32'd0);
            chk("idle_r_data", r_data, 32'd0);
        end

        // full write then read back, then byte-lane merge
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, RESP_OKAY, 1, 1);
        do_read(32'h8000_0010, 32'hDEAD_BEEF, RESP_OKAY);
        do_write(32'h8000_0012, 32'h0000_AB00, 4'b0010, 0, 0, RESP_OKAY, 1, 1);
        do_read(32'h8000_0010, 32'hDEAD_ABEF, RESP_OKAY);

        // W one cycle ahead of AW, B back-pressured for 5 cycles
        b_ready = 1'b0;
        do_write(32'h8000_0020, 32'h1234_5678, 4'hF, 1, 0, RESP_OKAY, 0, 0);
        repeat (WR_LAT - 1) @(posedge clk);
        #1;
        aw_valid = 1'b1; aw_addr = 32'h8000_0020;
        w_valid  = 1'b1; w_data  = 32'h0BAD_BAD0; w_strb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_b_valid", 32'(b_valid), 32'd1);
            chk("hold_aw_ready", 32'(aw_ready), 32'd0);
            chk("hold_w_ready", 32'(w_ready), 32'd0);
        end
        aw_valid = 1'b0; w_valid = 1'b0;
        b_ready  = 1'b1;
        drain();
        do_read(32'h8000_0020, 32'h1234_5678, RESP_OKAY);

        // out-of-range read and write; word 0 must survive
        do_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, 0, RESP_OKAY, 1, 1);
        do_read(32'h7FFF_FFFC, 32'h0000_0000, RESP_SLVERR);
        do_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 0, 0, RESP_SLVERR, 1, 1);
        do_read(32'h8000_0000, 32'hCAFE_F00D, RESP_OKAY);
        do_read(32'h8000_3FFC, 32'h0000_0000, RESP_OKAY);

        // strb=0 is a no-op with OKAY
        do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 0, 0, RESP_OKAY, 1, 1);
        do_read(32'h8000_0020, 32'h1234_5678, RESP_OKAY);

        // reset while the read engine is waiting
        @(posedge clk); #1;
        ar_valid = 1'b1; ar_addr = 32'h8000_0010;
        @(posedge clk); #1;
        ar_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_rd_r_valid", 32'(r_valid), 32'd0);
        chk("rst_rd_ar_ready", 32'(ar_ready), 32'd1);
        for (int i = 0; i < RD_LAT + 1; i++) begin
            @(posedge clk); #1;
            chk("rst_rd_quiet", 32'(r_valid), 32'd0);
        end

        // reset after AW captured but before W
        aw_valid = 1'b1; aw_addr = 32'h8000_0010;
        @(posedge clk); #1;
        aw_valid = 1'b0;
        chk("aw_held_ready", 32'(aw_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_wr_aw_ready", 32'(aw_ready), 32'd1);
        chk("rst_wr_w_ready", 32'(w_ready), 32'd1);
        w_valid = 1'b1; w_data = 32'h1111_1111; w_strb = 4'hF;
        @(posedge clk); #1;
        w_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rst_wr_no_b", 32'(b_valid), 32'd0);
        end
        chk("w_held_ready", 32'(w_ready), 32'd0);
        aw_valid = 1'b1; aw_addr = 32'h8000_0030;
        n = 0;
        while (!aw_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) fail("aw_after_w");
        @(posedge clk); #1;
        aw_valid = 1'b0;
        e.data = '0; e.resp = RESP_OKAY; e.cyc = cyc - 1 + WR_LAT;
        exp_b.push_back(e);
        drain();
        do_read(32'h8000_0010, 32'hDEAD_ABEF, RESP_OKAY);
        do_read(32'h8000_0030, 32'h1111_1111, RESP_OKAY);

        repeat (3) @(posedge clk);
        #1;
        chk("queues_empty", 32'(exp_r.size() + exp_b.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
